// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: states, opcodes,
// one-hot control words and fault codes.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [7:0] CTRL_NONE  = 8'h00;
  localparam logic [7:0] CTRL_ALU   = 8'h01;
  localparam logic [7:0] CTRL_LOAD  = 8'h02;
  localparam logic [7:0] CTRL_STORE = 8'h04;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_IMEM_TO = 2'd2;
  localparam logic [1:0] FC_DMEM_TO = 2'd3;

  // HALT and illegal opcodes both carry an empty control word.
  function automatic logic [7:0] op_to_ctrl(input logic [3:0] op);
    case (op)
      OP_ALU:   op_to_ctrl = CTRL_ALU;
      OP_LOAD:  op_to_ctrl = CTRL_LOAD;
      OP_STORE: op_to_ctrl = CTRL_STORE;
      default:  op_to_ctrl = CTRL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Memory-wait watchdog: counts cycles while enabled, clear has priority.
// o_hit flags the last permitted wait cycle (count == LIMIT-1).
module seq_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_hit = (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/mem/writeback sequencer with req/ack memory handshakes.
// Optional retired-instruction counter enabled by defining SEQ_PERF_COUNT_EN.
module instr_sequencer #(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [PC_W-1:0]    dmem_addr,
  input  logic               dmem_ack,
  output logic [INSTR_W-1:0] ir,
  output logic [7:0]         ctrl,
  output logic               alu_en,
  output logic               rf_we,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               fault,
  output logic [1:0]         fault_code
`ifdef SEQ_PERF_COUNT_EN
  ,
  output logic [31:0]        retired_cnt
`endif
);

  import seq_pkg::*;

  state_e             r_state, w_next;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [7:0]         r_ctrl;
  logic [1:0]         r_fault_code;
  logic [3:0]         w_opcode;
  logic               w_is_store, w_to_hit, w_to_en, w_to_clr;

  assign w_opcode   = r_ir[INSTR_W-1 -: 4];
  assign w_is_store = (r_ctrl == CTRL_STORE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)      w_next = S_DECODE;
        else if (w_to_hit) w_next = S_FAULT;
      end
      S_DECODE: begin
        case (w_opcode)
          OP_ALU:            w_next = S_EXEC;
          OP_LOAD, OP_STORE: w_next = S_MEM;
          OP_HALT:           w_next = S_HALT;
          default:           w_next = S_FAULT;
        endcase
      end
      S_EXEC:   w_next = S_WB;
      S_MEM: begin
        if (dmem_ack)      w_next = w_is_store ? S_FETCH : S_WB;
        else if (w_to_hit) w_next = S_FAULT;
      end
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
  end

  // Any state change clears the watchdog, so it starts at zero on FETCH/MEM entry.
  assign w_to_en  = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_to_clr = (w_next != r_state);

  seq_timeout_cnt #(.LIMIT(MEM_TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_to_clr),
    .i_en  (w_to_en),
    .o_hit (w_to_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_ir         <= '0;
      r_ctrl       <= CTRL_NONE;
      r_fault_code <= FC_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_ack) begin
        r_ir <= imem_rdata;
        r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == S_DECODE)    r_ctrl <= op_to_ctrl(w_opcode);
      else if (w_next == S_FETCH) r_ctrl <= CTRL_NONE;
      if (w_next == S_FAULT && r_state != S_FAULT) begin
        case (r_state)
          S_FETCH: r_fault_code <= FC_IMEM_TO;
          S_MEM:   r_fault_code <= FC_DMEM_TO;
          default: r_fault_code <= FC_ILLEGAL;
        endcase
      end
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = (r_state == S_MEM) && w_is_store;
  assign dmem_addr  = r_ir[PC_W-1:0];
  assign ir         = r_ir;
  assign ctrl       = r_ctrl;
  assign alu_en     = (r_state == S_EXEC);
  assign rf_we      = (r_state == S_WB);
  assign pc         = r_pc;
  assign halted     = (r_state == S_HALT);
  assign fault      = (r_state == S_FAULT);
  assign fault_code = r_fault_code;

`ifdef SEQ_PERF_COUNT_EN
  logic [31:0] r_retired_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_cnt <= '0;
    end else if ((r_state == S_WB) || (r_state == S_MEM && dmem_ack && w_is_store)) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table of single instructions plus
// hand-written sequences for timeout, halt, fault, pc wrap and mid-access reset.
module tb_instr_sequencer;

  localparam int PC_W = 8;
  localparam int INSTR_W = 16;
  localparam int MEM_TIMEOUT = 15;

  logic               clk, rst;
  logic               imem_req, imem_ack;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req, dmem_we, dmem_ack;
  logic [PC_W-1:0]    dmem_addr;
  logic [INSTR_W-1:0] ir;
  logic [7:0]         ctrl;
  logic               alu_en, rf_we, halted, fault;
  logic [PC_W-1:0]    pc;
  logic [1:0]         fault_code;
`ifdef SEQ_PERF_COUNT_EN
  logic [31:0]        retired_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instr_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .ir(ir), .ctrl(ctrl), .alu_en(alu_en), .rf_we(rf_we), .pc(pc),
    .halted(halted), .fault(fault), .fault_code(fault_code)
`ifdef SEQ_PERF_COUNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          ddelay;
    logic [7:0]  exp_ctrl;
    int          exp_alu;
    int          exp_rf;
    int          exp_dreq;
    logic        exp_we;
    logic [7:0]  exp_addr;
    int          exp_lat;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first FETCH cycle, sampled 1 time unit after the edge.
  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    imem_rdata = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  // Cycle 1 is the FETCH cycle in which the instruction is acked.
  task automatic run_instr(input vec_t v, input int idx);
    int cyc, alu_c, rf_c, nreq, lat;
    logic [7:0] ctrl_s, addr_s;
    logic we_s, ctrl_clr;
    cyc = 1; alu_c = 0; rf_c = 0; nreq = 0; lat = 0;
    ctrl_s = 8'hEE; addr_s = 8'hEE; we_s = 1'bx; ctrl_clr = 1'b0;
    chk($sformatf("v%0d_fetch_addr", idx), imem_addr, 8'(v.exp_pc - 8'd1));
    imem_ack = 1'b1;
    imem_rdata = v.instr;
    for (int k = 0; k < 40 && lat == 0; k++) begin
      step();
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      cyc++;
      if (imem_req) begin
        lat = cyc - 1;
        ctrl_clr = (ctrl == 8'h00);
      end else begin
        if (cyc == 3) ctrl_s = ctrl;
        if (alu_en) alu_c = cyc;
        if (rf_we) rf_c = cyc;
        if (dmem_req) begin
          nreq++;
          we_s = dmem_we;
          addr_s = dmem_addr;
          if (nreq == v.ddelay + 1) dmem_ack = 1'b1;
        end
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_ctrl", idx), ctrl_s, v.exp_ctrl);
    chk($sformatf("v%0d_alu_cycle", idx), alu_c, v.exp_alu);
    chk($sformatf("v%0d_rf_cycle", idx), rf_c, v.exp_rf);
    chk($sformatf("v%0d_dreq_cycles", idx), nreq, v.exp_dreq);
    if (v.exp_dreq != 0) begin
      chk($sformatf("v%0d_dmem_we", idx), we_s, v.exp_we);
      chk($sformatf("v%0d_dmem_addr", idx), addr_s, v.exp_addr);
    end
    chk($sformatf("v%0d_pc", idx), pc, v.exp_pc);
    chk($sformatf("v%0d_ctrl_cleared", idx), ctrl_clr, 1'b1);
  endtask

  initial begin
    int n_req;
    //          instr     dly ctrl   alu rf dreq we    addr   lat pc
    vecs[0] = '{16'h0012, 0, 8'h01, 3, 4, 0, 1'b0, 8'h00, 4, 8'h01};
    vecs[1] = '{16'h1034, 3, 8'h02, 0, 7, 4, 1'b0, 8'h34, 7, 8'h02};
    vecs[2] = '{16'h20FF, 0, 8'h04, 0, 0, 1, 1'b1, 8'hFF, 3, 8'h03};
    vecs[3] = '{16'h2011, 2, 8'h04, 0, 0, 3, 1'b1, 8'h11, 5, 8'h04};
    vecs[4] = '{16'h0ABC, 0, 8'h01, 3, 4, 0, 1'b0, 8'h00, 4, 8'h05};
    vecs[5] = '{16'h1000, 0, 8'h02, 0, 4, 1, 1'b0, 8'h00, 4, 8'h06};

    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    imem_rdata = '0;
    repeat (2) step();
    chk("rst_strobes", {imem_req, dmem_req, dmem_we, alu_en, rf_we, halted, fault}, 7'd0);
    chk("rst_pc_ir_ctrl", {pc, ir, ctrl}, 32'd0);
    chk("rst_fault_code", fault_code, 2'd0);
    rst = 1'b0;
    chk("idle_no_req", imem_req, 1'b0);
    step();
    chk("first_fetch_req", imem_req, 1'b1);
    chk("first_fetch_addr", imem_addr, 8'h00);

    for (int i = 0; i < 6; i++) run_instr(vecs[i], i);
`ifdef SEQ_PERF_COUNT_EN
    chk("retired_cnt", retired_cnt, 32'd6);
`endif

    // imem ack withheld: FAULT exactly MEM_TIMEOUT cycles after FETCH entry.
    do_reset();
    repeat (MEM_TIMEOUT - 1) step();
    chk("imem_to_still_fetch", {imem_req, fault}, 2'b10);
    step();
    chk("imem_to_fault", {imem_req, fault}, 2'b01);
    chk("imem_to_code", fault_code, 2'd2);

    // Ack in the limit cycle wins over the timeout.
    do_reset();
    repeat (MEM_TIMEOUT - 1) step();
    imem_ack = 1'b1;
    imem_rdata = 16'h0012;
    step();
    imem_ack = 1'b0;
    chk("limit_ack_no_fault", {fault, imem_req}, 2'b00);
    chk("limit_ack_ir", ir, 16'h0012);
    step();
    chk("limit_ack_exec", {alu_en, ctrl}, {1'b1, 8'h01});

    // Illegal opcode.
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 16'h5000;
    step();
    imem_ack = 1'b0;
    step();
    chk("illegal_fault", {fault, halted}, 2'b10);
    chk("illegal_code", fault_code, 2'd1);
    repeat (3) step();
    chk("illegal_strobes", {imem_req, dmem_req, alu_en, rf_we, ctrl}, 12'd0);
    chk("illegal_sticky", fault, 1'b1);

    // HALT is terminal: no further fetches.
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 16'hF000;
    step();
    imem_ack = 1'b0;
    step();
    chk("halt_flag", {halted, fault}, 2'b10);
    n_req = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (imem_req) n_req++;
    end
    chk("halt_no_fetch", n_req, 0);

    // pc wrap: run ALU instructions with ack held high until the fetch at 8'hFF.
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 16'h0012;
    for (int k = 0; k < 2000 && !(imem_req && imem_addr == 8'hFF); k++) step();
    chk("wrap_fetch_addr", {imem_req, imem_addr}, {1'b1, 8'hFF});
    step();
    imem_ack = 1'b0;
    chk("wrap_pc_zero", pc, 8'h00);

    // Reset asserted mid-MEM drops the request without waiting for a clock.
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 16'h1034;
    step();
    imem_ack = 1'b0;
    step();
    chk("mid_mem_req", {dmem_req, dmem_addr}, {1'b1, 8'h34});
    #2;
    rst = 1'b1;
    #1;
    chk("mid_mem_rst_strobes", {imem_req, dmem_req, dmem_we, alu_en, rf_we, halted, fault}, 7'd0);
    chk("mid_mem_rst_regs", {pc, ir, ctrl}, 32'd0);
    step();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM that sequences the processor datapath: fetch, decode, execute, memory access, writeback.
- Fetches instruction words over a req/ack handshake and decodes the 4-bit opcode to one-hot control signals, using the team's existing opcode map.
- Drives ALU, register-file and data-memory strobes, one phase per cycle.
- Sits between instruction/data memory and the datapath; it is the processor's sole sequencing source.

Parameters:
- PC_W, 8, program counter and memory address width.
- INSTR_W, 16, instruction width. Opcode is ir[INSTR_W-1 -: 4]. Memory operand address is ir[PC_W-1:0].
- MEM_TIMEOUT, 15, maximum wait cycles for an ack before FAULT. Must be at least 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; qualified by dmem_req.
- dmem_addr  out  PC_W  data address, ir[PC_W-1:0].
- dmem_ack  in  1  data access complete.
- ir  out  INSTR_W  instruction register.
- ctrl  out  8  one-hot control word for the current instruction.
- alu_en  out  1  ALU execute strobe.
- rf_we  out  1  register-file write strobe.
- pc  out  PC_W  program counter.
- halted  out  1  HALT executed.
- fault  out  1  sticky fault flag.
- fault_code  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout.

Behaviour:
- Reset (async, immediate): state=IDLE; pc, ir, ctrl, fault_code and timeout counter = 0. All strobe and flag outputs = 0. Requests drop in the same cycle reset asserts, including mid-handshake.
- Strobes are Moore outputs, decoded from the state register.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir<=imem_rdata, pc<=pc+1 (wraps modulo 2^PC_W), go to DECODE.
- DECODE: ctrl<=one-hot of opcode, then:
  - 0000 -> 8'h01, go to EXEC (ALU).
  - 0001 -> 8'h02, go to MEM (LOAD).
  - 0010 -> 8'h04, go to MEM (STORE).
  - 1111 -> 8'h00, go to HALT.
  - any other -> 8'h00, fault_code=1, go to FAULT.
- EXEC: alu_en=1 for exactly one cycle, then go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 only for STORE.
  - On dmem_ack: LOAD goes to WB; STORE goes to FETCH (retires).
- WB: rf_we=1 for exactly one cycle, then go to FETCH (retires).
- ctrl is held from DECODE until retirement and cleared to 0 on entering FETCH.
- HALT: halted=1. Terminal until reset.
- FAULT: fault=1. Terminal until reset.
- Timeout counter:
  - Cleared on entry to FETCH or MEM; increments each cycle in those states without an ack.
  - Width $clog2(MEM_TIMEOUT+1).
  - If count == MEM_TIMEOUT-1 and no ack: go to FAULT with code 2 (FETCH) or 3 (MEM).
  - An ack in the limit cycle wins over timeout.
- Acks received in any state other than the one that issued the request are ignored.
- Latency with same-cycle ack: ALU = 4 cycles (FETCH, DECODE, EXEC, WB), LOAD = 4, STORE = 3.

Optional Feature:
- Macro SEQ_PERF_COUNT_EN.
- Defined: adds output retired_cnt (32-bit), reset to 0, incremented on every retirement (WB exit or STORE ack). Wraps at 2^32.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package seq_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT (3-bit).
  - opcode constants OP_ALU, OP_LOAD, OP_STORE, OP_HALT.
  - ctrl one-hot constants.
  - fault_code constants.
- One natural sub-module: seq_timeout_cnt (clear, enable, hit output).

Test Plan:
- ALU instr 16'h0012, same-cycle imem_ack -> ctrl=8'h01; alu_en cycle 3, rf_we cycle 4; pc 0->1; next fetch at addr 1.
- LOAD 16'h1034, dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0, dmem_addr=8'h34 held 4 cycles; then rf_we pulse.
- STORE 16'h20FF -> dmem_we=1, dmem_addr=8'hFF; no rf_we; returns to FETCH after ack.
- Opcode 4'b0101 -> fault=1, fault_code=1, all strobes 0 thereafter; opcode 4'b1111 -> halted=1, no further imem_req.
- imem_ack withheld -> FAULT, code 2, exactly MEM_TIMEOUT cycles after FETCH entry; ack in the limit cycle instead -> DECODE, no fault.
- pc=8'hFF fetch -> pc wraps to 0; rst asserted mid-MEM -> dmem_req drops in the same cycle, all outputs 0.
